// File: rtl/nba_grader.sv
// Number-baseball scoring block: accepts 4-digit guesses, replies strike/ball counts, counts questions.
// Optional macro GRADER_DIGIT_CHECK_EN: guesses with a digit > 9 or a repeated digit score 0/0.
module nba_grader #(
   parameter int MAX_Q = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] answer,
   input  logic [15:0] question,
   input  logic        ask_valid,
   output logic        ask_ready,
   output logic [2:0]  strike,
   output logic [2:0]  ball,
   output logic [15:0] cnt,
   output logic        reply_valid,
   input  logic        reply_ready,
   output logic        correct
);

   localparam logic [15:0] MAX_Q_W = 16'(MAX_Q);

   typedef enum logic [1:0] {ASK, REPLY, DONE} state_t;

   state_t      state_reg, state_next;
   logic        armed_reg;
   logic [2:0]  strike_reg, ball_reg;
   logic [15:0] cnt_reg;
   logic        correct_reg;

   logic [3:0]  a_dig [4];
   logic [3:0]  q_dig [4];
   logic [3:0]  hit_s, hit_b;
   logic [2:0]  raw_s, raw_b, score_s, score_b;
   logic        accept;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign a_dig[gi] = answer[gi*4 +: 4];
         assign q_dig[gi] = question[gi*4 +: 4];
         assign hit_s[gi] = (q_dig[gi] == a_dig[gi]);
      end
   endgenerate

   // A ball needs an answer digit elsewhere that is not already taken by a strike.
   always_comb begin
      hit_b = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (j != i && !hit_s[i] && !hit_s[j] && q_dig[i] == a_dig[j])
               hit_b[i] = 1'b1;
         end
      end
   end

   assign raw_s = {2'b00, hit_s[0]} + {2'b00, hit_s[1]} + {2'b00, hit_s[2]} + {2'b00, hit_s[3]};
   assign raw_b = {2'b00, hit_b[0]} + {2'b00, hit_b[1]} + {2'b00, hit_b[2]} + {2'b00, hit_b[3]};

`ifdef GRADER_DIGIT_CHECK_EN
   logic digits_ok;
   always_comb begin
      digits_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (q_dig[i] > 4'd9)
            digits_ok = 1'b0;
         for (int j = i + 1; j < 4; j++) begin
            if (q_dig[i] == q_dig[j])
               digits_ok = 1'b0;
         end
      end
   end
   assign score_s = digits_ok ? raw_s : 3'd0;
   assign score_b = digits_ok ? raw_b : 3'd0;
`else
   assign score_s = raw_s;
   assign score_b = raw_b;
`endif

   assign accept      = (state_reg == ASK) && armed_reg && ask_valid;
   assign ask_ready   = (state_reg == ASK) && armed_reg;
   assign reply_valid = (state_reg == REPLY);
   assign strike      = strike_reg;
   assign ball        = ball_reg;
   assign cnt         = cnt_reg;
   assign correct     = correct_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ASK:     if (accept) state_next = REPLY;
         REPLY:   if (reply_ready)
                     state_next = (correct_reg || cnt_reg == MAX_Q_W) ? DONE : ASK;
         DONE:    state_next = DONE;
         default: state_next = ASK;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ASK;
         armed_reg   <= 1'b0;
         strike_reg  <= 3'd0;
         ball_reg    <= 3'd0;
         cnt_reg     <= 16'd0;
         correct_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         armed_reg <= 1'b1;
         if (accept) begin
            strike_reg  <= score_s;
            ball_reg    <= score_b;
            correct_reg <= correct_reg || (score_s == 3'd4);
            if (cnt_reg != MAX_Q_W)
               cnt_reg <= cnt_reg + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_nba_grader.sv
// Self-checking bench for nba_grader: vector table, hand sequences and randomized rounds vs. a digit-level model.
module tb_nba_grader;

   localparam int MAXQ = 200;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] answer = 16'h0;
   logic [15:0] question = 16'h0;
   logic        ask_valid = 1'b0;
   logic        ask_ready;
   logic [2:0]  strike, ball;
   logic [15:0] cnt;
   logic        reply_valid;
   logic        reply_ready = 1'b0;
   logic        correct;

   int checks = 0;
   int failures = 0;
   int m_cnt = 0;
   bit m_correct = 0;
   bit m_done = 0;

   nba_grader #(.MAX_Q(MAXQ)) dut (
      .clk(clk), .reset(reset), .answer(answer), .question(question),
      .ask_valid(ask_valid), .ask_ready(ask_ready), .strike(strike), .ball(ball),
      .cnt(cnt), .reply_valid(reply_valid), .reply_ready(reply_ready), .correct(correct)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference scoring straight from the game rules, digit by digit.
   function automatic void model_score(input logic [15:0] a, input logic [15:0] q,
                                       output int s, output int b);
      int ad[4];
      int qd[4];
      bit used[4];
      s = 0;
      b = 0;
      for (int i = 0; i < 4; i++) begin
         ad[i] = int'(a[i*4 +: 4]);
         qd[i] = int'(q[i*4 +: 4]);
      end
`ifdef GRADER_DIGIT_CHECK_EN
      for (int i = 0; i < 4; i++) begin
         if (qd[i] > 9) return;
         for (int j = 0; j < 4; j++)
            if (j != i && qd[i] == qd[j]) return;
      end
`endif
      for (int i = 0; i < 4; i++) begin
         used[i] = (qd[i] == ad[i]);
         if (used[i]) s++;
      end
      for (int i = 0; i < 4; i++) begin
         bit found = 0;
         if (qd[i] != ad[i])
            for (int j = 0; j < 4; j++)
               if (j != i && !used[j] && qd[i] == ad[j]) found = 1;
         if (found) b++;
      end
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ask_ready", ask_ready, 0);
      chk("rst_reply_valid", reply_valid, 0);
      chk("rst_correct", correct, 0);
      chk("rst_strike", strike, 0);
      chk("rst_ball", ball, 0);
      chk("rst_cnt", cnt, 0);
      @(negedge clk);
      reset = 1'b1;
      m_cnt = 0;
      m_correct = 0;
      m_done = 0;
      #1;
      chk("rel_ask_ready_low", ask_ready, 0);
      @(posedge clk);
      #1;
      chk("rel_ask_ready_rise", ask_ready, 1);
   endtask

   // Present a guess, wait for acceptance, check the registered reply.
   task automatic send_q(input logic [15:0] a, input logic [15:0] q, input int es, input int eb);
      int waited = 0;
      @(negedge clk);
      answer = a;
      question = q;
      ask_valid = 1'b1;
      while (!ask_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!ask_ready) begin
         chk("ask_timeout", 0, 1);
         ask_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      ask_valid = 1'b0;
      if (m_cnt < MAXQ) m_cnt++;
      if (es == 4) m_correct = 1;
      chk("reply_valid", reply_valid, 1);
      chk("reply_ask_ready", ask_ready, 0);
      chk("strike", strike, es);
      chk("ball", ball, eb);
      chk("correct", correct, int'(m_correct));
      chk("cnt", cnt, m_cnt);
      $display("ask a=%h q=%h -> strike=%0d ball=%0d correct=%0d cnt=%0d", a, q, strike, ball, correct, cnt);
      answer = 16'($urandom);
      question = 16'($urandom);
   endtask

   task automatic take_reply(input int hold, input int es, input int eb);
      repeat (hold) begin
         @(negedge clk);
         chk("stall_reply_valid", reply_valid, 1);
         chk("stall_ask_ready", ask_ready, 0);
         chk("stall_strike", strike, es);
         chk("stall_ball", ball, eb);
      end
      @(negedge clk);
      reply_ready = 1'b1;
      @(posedge clk);
      #1;
      reply_ready = 1'b0;
      m_done = m_correct || (m_cnt == MAXQ);
      chk("hs_reply_valid", reply_valid, 0);
      chk("hs_ask_ready", ask_ready, m_done ? 0 : 1);
   endtask

   task automatic check_done(input int es);
      @(negedge clk);
      ask_valid = 1'b1;
      question = answer;
      repeat (6) begin
         @(negedge clk);
         chk("done_ask_ready", ask_ready, 0);
         chk("done_reply_valid", reply_valid, 0);
         chk("done_cnt", cnt, m_cnt);
         chk("done_correct", correct, int'(m_correct));
         chk("done_strike", strike, es);
      end
      ask_valid = 1'b0;
   endtask

   typedef struct {
      logic [15:0] q;
      int          s;
      int          b;
      int          hold;
   } vec_t;

   initial begin
      vec_t tbl[6];
      int s, b;
      logic [15:0] a, q;

      tbl[0] = '{16'h4321, 0, 4, 0};
      tbl[1] = '{16'h1243, 2, 2, 5};
      tbl[2] = '{16'h5678, 0, 0, 1};
      tbl[3] = '{16'h1235, 3, 0, 0};
      tbl[4] = '{16'h2143, 0, 4, 2};
`ifdef GRADER_DIGIT_CHECK_EN
      tbl[5] = '{16'h1134, 0, 0, 0};
`else
      tbl[5] = '{16'h1134, 3, 0, 0};
`endif

      repeat (3) @(negedge clk);
      apply_reset();

      for (int i = 0; i < 6; i++) begin
         send_q(16'h1234, tbl[i].q, tbl[i].s, tbl[i].b);
         take_reply(tbl[i].hold, tbl[i].s, tbl[i].b);
      end

      // Exact guess ends the round and parks in DONE.
      apply_reset();
      send_q(16'h1234, 16'h1234, 4, 0);
      take_reply(0, 4, 0);
      check_done(4);

      // Reset during REPLY clears outputs without waiting for a clock edge.
      apply_reset();
      send_q(16'h1234, 16'h1243, 2, 2);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_reply_valid", reply_valid, 0);
      chk("mid_rst_strike", strike, 0);
      chk("mid_rst_ball", ball, 0);
      chk("mid_rst_cnt", cnt, 0);
      chk("mid_rst_ask_ready", ask_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      m_cnt = 0;
      m_correct = 0;
      @(posedge clk);
      #1;
      chk("mid_rst_ask_rise", ask_ready, 1);
      send_q(16'h1234, 16'h5678, 0, 0);
      take_reply(0, 0, 0);

      // Question cap with wrong guesses only.
      apply_reset();
      a = 16'h3719;
      for (int i = 0; i < MAXQ; i++) begin
         q = 16'($urandom);
         model_score(a, q, s, b);
         if (s == 4) begin
            q = a ^ 16'h1111;
            model_score(a, q, s, b);
         end
         send_q(a, q, s, b);
         take_reply(0, s, b);
      end
      chk("cap_cnt", cnt, MAXQ);
      answer = a;
      check_done(s);

      // Randomized rounds with digit shuffles of the answer.
      for (int r = 0; r < 6; r++) begin
         apply_reset();
         a = 16'($urandom);
         for (int k = 0; k < 10 && !m_done; k++) begin
            case ($urandom_range(0, 3))
               0: q = a;
               1: q = 16'($urandom);
               default: for (int d = 0; d < 4; d++)
                           q[d*4 +: 4] = a[$urandom_range(0, 3)*4 +: 4];
            endcase
            model_score(a, q, s, b);
            send_q(a, q, s, b);
            take_reply($urandom_range(0, 3), s, b);
         end
         if (m_done) check_done(s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
